// File: rtl/sonar_pkg.sv
// rtl/sonar_pkg.sv - shared state encoding and default widths for the sonar ping scheduler
package sonar_pkg;

  localparam int DEF_N_CH    = 4;
  localparam int DEF_LEN_W   = 16;
  localparam int DEF_BURST_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TX     = 3'd1,
    S_GUARD  = 3'd2,
    S_LISTEN = 3'd3,
    S_REPORT = 3'd4
  } state_t;

endpackage

// File: rtl/ch_mask_next.sv
// rtl/ch_mask_next.sv - next higher set channel in a mask, wrapping to the lowest set channel
module ch_mask_next #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] mask,
  input  logic [CH_W-1:0] cur,
  output logic [CH_W-1:0] nxt,
  output logic            wrap
);

  logic [CH_W-1:0] lowest;

  // Descending scan: the last hit written is the lowest qualifying index.
  always_comb begin
    nxt    = '0;
    wrap   = 1'b1;
    lowest = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest = CH_W'(i);
        if (i > int'(cur)) begin
          nxt  = CH_W'(i);
          wrap = 1'b0;
        end
      end
    end
    if (wrap) nxt = lowest;
  end

endmodule

// File: rtl/sonar_ping_scheduler.sv
// rtl/sonar_ping_scheduler.sv - TX/GUARD/LISTEN/REPORT ping sequencer over a channel mask
// Optional SONAR_SCHED_TIMESTAMP_EN: per-ping timestamp from a free-running 32-bit counter.
module sonar_ping_scheduler
  import sonar_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int BURST_W = DEF_BURST_W,
  parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [N_CH-1:0]    ch_mask,
  input  logic [BURST_W-1:0] n_bursts,
  input  logic [LEN_W-1:0]   tx_len,
  input  logic [LEN_W-1:0]   guard_len,
  input  logic [LEN_W-1:0]   listen_len,
  output logic               tx_en,
  output logic [CH_W-1:0]    tx_ch,
  output logic               rx_win,
  output logic               desc_valid,
  input  logic               desc_ready,
  output logic [CH_W-1:0]    desc_ch,
  output logic [BURST_W-1:0] desc_burst,
  output logic [31:0]        desc_ts,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [N_CH-1:0]    mask_q, mask_d;
  logic [BURST_W-1:0] nb_q, nb_d;
  logic [LEN_W-1:0]   tx_len_q, tx_len_d;
  logic [LEN_W-1:0]   guard_q, guard_d;
  logic [LEN_W-1:0]   listen_q, listen_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
`ifdef SONAR_SCHED_TIMESTAMP_EN
  logic [31:0]        tmr_q, tmr_d;
  logic [31:0]        ts_q, ts_d;
`endif

  logic [N_CH-1:0]    mask_sel;
  logic [CH_W-1:0]    cur_sel;
  logic [CH_W-1:0]    next_ch;
  logic               next_wrap;
  logic [LEN_W:0]     cnt_inc;
  logic               tx_last, guard_last, listen_last;

  // In IDLE the walker looks at the incoming mask from the top index, so it yields the lowest set bit.
  assign mask_sel = (state_q == S_IDLE) ? ch_mask : mask_q;
  assign cur_sel  = (state_q == S_IDLE) ? CH_W'(N_CH - 1) : ch_q;

  ch_mask_next #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_ch_mask_next (
    .mask (mask_sel),
    .cur  (cur_sel),
    .nxt  (next_ch),
    .wrap (next_wrap)
  );

  // Zero-length TX/LISTEN behave as one cycle: cnt+1 >= 0 is always true.
  assign cnt_inc     = {1'b0, cnt_q} + (LEN_W + 1)'(1);
  assign tx_last     = cnt_inc >= {1'b0, tx_len_q};
  assign guard_last  = cnt_inc >= {1'b0, guard_q};
  assign listen_last = cnt_inc >= {1'b0, listen_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    burst_d   = burst_q;
    mask_d    = mask_q;
    nb_d      = nb_q;
    tx_len_d  = tx_len_q;
    guard_d   = guard_q;
    listen_d  = listen_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
`ifdef SONAR_SCHED_TIMESTAMP_EN
    tmr_d     = tmr_q + 32'd1;
    ts_d      = ts_q;
`endif
    if (abort) begin
      if (state_q != S_IDLE) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (ch_mask == '0 || n_bursts == '0) begin
              cfg_err_d = 1'b1;
            end else begin
              mask_d   = ch_mask;
              nb_d     = n_bursts;
              tx_len_d = tx_len;
              guard_d  = guard_len;
              listen_d = listen_len;
              ch_d     = next_ch;
              burst_d  = '0;
              cnt_d    = '0;
              state_d  = S_TX;
            end
          end
        end
        S_TX: begin
`ifdef SONAR_SCHED_TIMESTAMP_EN
          if (cnt_q == '0) ts_d = tmr_q;
`endif
          if (tx_last) begin
            cnt_d   = '0;
            state_d = (guard_q == '0) ? S_LISTEN : S_GUARD;
          end else begin
            cnt_d = cnt_inc[LEN_W-1:0];
          end
        end
        S_GUARD: begin
          if (guard_last) begin
            cnt_d   = '0;
            state_d = S_LISTEN;
          end else begin
            cnt_d = cnt_inc[LEN_W-1:0];
          end
        end
        S_LISTEN: begin
          if (listen_last) begin
            cnt_d   = '0;
            state_d = S_REPORT;
          end else begin
            cnt_d = cnt_inc[LEN_W-1:0];
          end
        end
        S_REPORT: begin
          if (desc_ready) begin
            if (next_wrap && burst_q == nb_q - BURST_W'(1)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              ch_d    = next_ch;
              burst_d = next_wrap ? burst_q + BURST_W'(1) : burst_q;
              cnt_d   = '0;
              state_d = S_TX;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ch_q      <= '0;
      burst_q   <= '0;
      mask_q    <= '0;
      nb_q      <= '0;
      tx_len_q  <= '0;
      guard_q   <= '0;
      listen_q  <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
`ifdef SONAR_SCHED_TIMESTAMP_EN
      tmr_q     <= '0;
      ts_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      burst_q   <= burst_d;
      mask_q    <= mask_d;
      nb_q      <= nb_d;
      tx_len_q  <= tx_len_d;
      guard_q   <= guard_d;
      listen_q  <= listen_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
`ifdef SONAR_SCHED_TIMESTAMP_EN
      tmr_q     <= tmr_d;
      ts_q      <= ts_d;
`endif
    end
  end

  assign tx_en      = (state_q == S_TX);
  assign tx_ch      = tx_en ? ch_q : '0;
  assign rx_win     = (state_q == S_LISTEN);
  assign desc_valid = (state_q == S_REPORT);
  assign desc_ch    = desc_valid ? ch_q : '0;
  assign desc_burst = desc_valid ? burst_q : '0;
`ifdef SONAR_SCHED_TIMESTAMP_EN
  assign desc_ts    = desc_valid ? ts_q : '0;
`else
  assign desc_ts    = '0;
`endif
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_sonar_ping_scheduler.sv
// tb/tb_sonar_ping_scheduler.sv - randomized self-checking bench for sonar_ping_scheduler
module tb_sonar_ping_scheduler;

  logic        clk, rst, start, abort;
  logic [3:0]  ch_mask;
  logic [7:0]  n_bursts;
  logic [15:0] tx_len, guard_len, listen_len;
  logic        tx_en, rx_win, desc_valid, desc_ready, busy, done, cfg_err;
  logic [1:0]  tx_ch, desc_ch;
  logic [7:0]  desc_burst;
  logic [31:0] desc_ts;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       tx_en;
    logic [1:0] tx_ch;
    logic       rx_win;
    logic       dv;
    logic [1:0] dch;
    logic [7:0] db;
    logic       busy;
    logic       done;
    logic       cfg_err;
  } exp_t;

  sonar_ping_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .ch_mask(ch_mask), .n_bursts(n_bursts), .tx_len(tx_len),
    .guard_len(guard_len), .listen_len(listen_len),
    .tx_en(tx_en), .tx_ch(tx_ch), .rx_win(rx_win),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_ch(desc_ch), .desc_burst(desc_burst), .desc_ts(desc_ts),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t observe();
    exp_t a;
    a = {tx_en, tx_ch, rx_win, desc_valid, desc_ch, desc_burst, busy, done, cfg_err};
    return a;
  endfunction

  // Expected cycle-by-cycle trace of a whole sequence, built from the phase rules, then replayed.
  task automatic play(input string name, input logic [3:0] m, input int nb, input int tx,
                      input int g, input int l, input int st_lo, input int st_hi,
                      input bit do_abort);
    exp_t q[$];
    bit   rdyq[$];
    int   pst[$];
    exp_t e, a;
    int   ab, ping_start, stall, tx_c, l_c;
    bit   have_base;
    logic [31:0] base, want_ts;
    tx_c = (tx < 1) ? 1 : tx;
    l_c  = (l < 1) ? 1 : l;
    have_base = 1'b0;
    base = '0;
    ab = -1;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < 4; c++) begin
        if (m[c]) begin
          ping_start = q.size();
          e = '0; e.busy = 1'b1; e.tx_en = 1'b1; e.tx_ch = c[1:0];
          repeat (tx_c) begin q.push_back(e); rdyq.push_back(1'b0); pst.push_back(-1); end
          e = '0; e.busy = 1'b1;
          repeat (g) begin q.push_back(e); rdyq.push_back(1'b0); pst.push_back(-1); end
          e.rx_win = 1'b1;
          repeat (l_c) begin q.push_back(e); rdyq.push_back(1'b0); pst.push_back(-1); end
          e = '0; e.busy = 1'b1; e.dv = 1'b1; e.dch = c[1:0]; e.db = b[7:0];
          stall = $urandom_range(st_hi, st_lo);
          repeat (stall) begin q.push_back(e); rdyq.push_back(1'b0); pst.push_back(-1); end
          q.push_back(e); rdyq.push_back(1'b1); pst.push_back(ping_start);
        end
      end
    end
    if (do_abort) begin
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].rx_win) ab = i;
      q = q[0:ab]; rdyq = rdyq[0:ab]; pst = pst[0:ab];
    end else begin
      e = '0; e.done = 1'b1;
      q.push_back(e); rdyq.push_back(1'b0); pst.push_back(-1);
    end
    e = '0;
    repeat (2) begin q.push_back(e); rdyq.push_back(1'b0); pst.push_back(-1); end

    @(negedge clk);
    ch_mask = m; n_bursts = nb[7:0]; tx_len = tx[15:0]; guard_len = g[15:0];
    listen_len = l[15:0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      a = observe();
      vectors++;
      if (a !== q[i]) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, i, a, q[i]);
      end
      if (pst[i] >= 0) begin
`ifdef SONAR_SCHED_TIMESTAMP_EN
        if (!have_base) begin
          base = desc_ts - 32'(pst[i]);
          have_base = 1'b1;
        end else begin
          want_ts = base + 32'(pst[i]);
          vectors++;
          if (desc_ts !== want_ts) begin
            miscompares++;
            $display("FAIL %s ts cycle %0d: got %0d expected %0d", name, i, desc_ts, want_ts);
          end
        end
`else
        want_ts = '0;
        vectors++;
        if (desc_ts !== want_ts) begin
          miscompares++;
          $display("FAIL %s ts cycle %0d: got %0d expected 0", name, i, desc_ts);
        end
`endif
      end
      desc_ready = rdyq[i];
      abort = do_abort && (i == ab);
      start = q[i].busy ? 1'($urandom_range(1, 0)) : 1'b0;
      ch_mask = 4'($urandom); n_bursts = 8'($urandom);
      tx_len = 16'($urandom_range(9, 0)); guard_len = 16'($urandom_range(9, 0));
      listen_len = 16'($urandom_range(9, 0));
      @(negedge clk);
    end
    desc_ready = 1'b0; abort = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (observe() !== '0 || desc_ts !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_hold: got %h/%h expected 0", observe(), desc_ts);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (observe() !== '0) begin
      miscompares++;
      $display("FAIL reset_release: got %h expected 0", observe());
    end
  endtask

  task automatic test_basic();
    play("basic_0101", 4'b0101, 1, 3, 2, 4, 0, 0, 1'b0);
  endtask

  task automatic test_bursts();
    play("bursts_1000", 4'b1000, 3, 2, 1, 2, 0, 1, 1'b0);
  endtask

  task automatic test_stall();
    play("stall10", 4'b0011, 1, 1, 1, 1, 10, 10, 1'b0);
  endtask

  task automatic test_abort();
    play("abort_listen", 4'b0110, 2, 2, 1, 3, 0, 0, 1'b1);
    play("after_abort", 4'b0001, 1, 1, 0, 1, 0, 0, 1'b0);
  endtask

  task automatic test_abort_start_idle();
    @(negedge clk);
    ch_mask = 4'b0001; n_bursts = 8'd1; tx_len = 16'd1; guard_len = 16'd0;
    listen_len = 16'd1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    vectors++;
    if (observe() !== '0) begin
      miscompares++;
      $display("FAIL abort_start_idle: got %h expected 0", observe());
    end
  endtask

  task automatic test_cfg_err();
    exp_t want;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      ch_mask = (k == 0) ? 4'b0000 : 4'b0101;
      n_bursts = (k == 0) ? 8'd2 : 8'd0;
      tx_len = 16'd1; guard_len = 16'd1; listen_len = 16'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      want = '0; want.cfg_err = 1'b1;
      vectors++;
      if (observe() !== want) begin
        miscompares++;
        $display("FAIL cfg_err_pulse%0d: got %h expected %h", k, observe(), want);
      end
      @(negedge clk);
      vectors++;
      if (observe() !== '0) begin
        miscompares++;
        $display("FAIL cfg_err_clear%0d: got %h expected 0", k, observe());
      end
    end
  endtask

  task automatic test_zero_len();
    play("zero_len", 4'b1111, 2, 0, 0, 2, 0, 3, 1'b0);
    play("zero_listen", 4'b1010, 1, 0, 1, 0, 0, 2, 1'b0);
  endtask

  task automatic test_reset_override();
    @(negedge clk);
    ch_mask = 4'b0001; n_bursts = 8'd1; tx_len = 16'd4; guard_len = 16'd1;
    listen_len = 16'd1; start = 1'b1; abort = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    vectors++;
    if (observe() !== '0) begin
      miscompares++;
      $display("FAIL rst_over_start: got %h expected 0", observe());
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (observe() !== '0 || desc_ts !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_mid_seq: got %h expected 0", observe());
    end
  endtask

  task automatic test_random();
    logic [3:0] m;
    for (int n = 0; n < 20; n++) begin
      m = 4'($urandom_range(15, 1));
      play("random", m, $urandom_range(3, 1), $urandom_range(4, 0), $urandom_range(3, 0),
           $urandom_range(4, 0), 0, 3, (n % 5) == 4);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ch_mask = '0; n_bursts = '0;
    tx_len = '0; guard_len = '0; listen_len = '0; desc_ready = 1'b0;
    test_reset();
    test_basic();
    test_bursts();
    test_stall();
    test_abort();
    test_abort_start_idle();
    test_cfg_err();
    test_zero_len();
    test_reset_override();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
